// File: rtl/sram_arb_pkg.sv
// Shared helpers for the SRAM request arbiter: width helpers and the
// rotating-priority search used to pick the next candidate channel.
package sram_arb_pkg;

   localparam int MAX_NCH = 8;

   // Channel-ID width; a single-channel build still needs one bit
   function automatic int id_width(input int nch);
      return (nch > 1) ? $clog2(nch) : 1;
   endfunction

   // Occupancy counter width: one extra bit so DEPTH itself is representable
   function automatic int cnt_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

   // First set bit of vld, searching upward from ptr and wrapping modulo nch.
   // Returns ptr when nothing is set (the result is then unused).
   function automatic int rr_pick(input logic [MAX_NCH-1:0] vld, input int ptr, input int nch);
      int   pick;
      int   idx;
      logic found;
      pick  = ptr;
      idx   = 0;
      found = 1'b0;
      for (int k = 0; k < MAX_NCH; k++) begin
         if (!found && (k < nch)) begin
            idx = (ptr + k) % nch;
            if (vld[idx]) begin
               pick  = idx;
               found = 1'b1;
            end
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/id_fifo.sv
// Synchronous FIFO holding the channel IDs of issued, unanswered transactions.
// Pointers carry one wrap bit so full and empty are distinguishable.
module id_fifo #(
   parameter int W     = 1,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     push,
   input  logic [W-1:0]             din,
   input  logic                     pop,
   output logic [W-1:0]             dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AWF = $clog2(DEPTH);
   localparam int PW  = AWF + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = ((wr_ptr ^ rd_ptr) == {1'b1, {AWF{1'b0}}});
   assign count = wr_ptr - rd_ptr;
   assign dout  = mem[rd_ptr[AWF-1:0]];

   // Pointer update; push and pop in one cycle both take effect
   always_ff @(posedge clk) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full) wr_ptr <= wr_ptr + 1'b1;
         if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // ID storage; contents are meaningless while empty, so no reset
   always_ff @(posedge clk) begin
      if (push && !full) mem[wr_ptr[AWF-1:0]] <= din;
   end

endmodule

// File: rtl/sram_req_arbiter.sv
// Round-robin arbiter merging NCH SRAM-like request ports onto one memory
// port. Issued channel IDs are queued so in-order responses return to their
// issuer combinationally in the cycle mem_data_ok arrives.
module sram_req_arbiter
   import sram_arb_pkg::*;
#(
   parameter int NCH   = 2,
   parameter int AW    = 32,
   parameter int DW    = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic [NCH-1:0]           req_valid,
   output logic [NCH-1:0]           req_ready,
   input  logic [NCH*(DW/8)-1:0]    req_we,
   input  logic [NCH*AW-1:0]        req_addr,
   input  logic [NCH*DW-1:0]        req_wdata,
   output logic [NCH-1:0]           resp_valid,
   output logic [DW-1:0]            resp_rdata,
   output logic                     mem_req,
   input  logic                     mem_addr_ok,
   output logic [DW/8-1:0]          mem_we,
   output logic [AW-1:0]            mem_addr,
   output logic [DW-1:0]            mem_wdata,
   input  logic                     mem_data_ok,
   input  logic [DW-1:0]            mem_rdata,
   output logic [$clog2(DEPTH):0]   outstanding,
   output logic                     err_orphan
);

   localparam int BW  = DW / 8;
   localparam int IDW = id_width(NCH);

   logic [IDW-1:0] rr_ptr;
   logic [IDW-1:0] rr_next;
   logic [IDW-1:0] cand;
   logic [IDW-1:0] head_id;
   logic           fifo_full;
   logic           fifo_empty;
   logic           accept;
   logic           pop;

   // Candidate selection, request mux, grant and response routing
   always_comb begin
      cand       = IDW'(rr_pick(MAX_NCH'(req_valid), int'(rr_ptr), NCH));
      rr_next    = (int'(cand) == NCH - 1) ? '0 : cand + 1'b1;
      // Reset gates every strobe so nothing leaves the block while resetn is low
      mem_req    = resetn & (|req_valid) & ~fifo_full;
      accept     = mem_req & mem_addr_ok;
      pop        = resetn & mem_data_ok & ~fifo_empty;
      mem_we     = req_we[int'(cand)*BW +: BW];
      mem_addr   = req_addr[int'(cand)*AW +: AW];
      mem_wdata  = req_wdata[int'(cand)*DW +: DW];
      resp_rdata = mem_rdata;
      req_ready  = '0;
      resp_valid = '0;
      if (accept) req_ready[cand]   = 1'b1;
      if (pop)    resp_valid[head_id] = 1'b1;
   end

   // Rotate priority past the channel just served; hold otherwise
   always_ff @(posedge clk) begin
      if (!resetn)     rr_ptr <= '0;
      else if (accept) rr_ptr <= rr_next;
   end

   // Sticky flag for a response that has no issuer to return to
   always_ff @(posedge clk) begin
      if (!resetn)                        err_orphan <= 1'b0;
      else if (mem_data_ok && fifo_empty) err_orphan <= 1'b1;
   end

   id_fifo #(
      .W     (IDW),
      .DEPTH (DEPTH)
   ) u_id_fifo (
      .clk    (clk),
      .resetn (resetn),
      .push   (accept),
      .din    (cand),
      .pop    (pop),
      .dout   (head_id),
      .full   (fifo_full),
      .empty  (fifo_empty),
      .count  (outstanding)
   );

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed bench for sram_req_arbiter (NCH=2, DEPTH=4).
module tb_sram_req_arbiter;

   localparam int NCH   = 2;
   localparam int AW    = 32;
   localparam int DW    = 32;
   localparam int DEPTH = 4;

   logic                  clk = 1'b0;
   logic                  resetn;
   logic [NCH-1:0]        req_valid;
   logic [NCH-1:0]        req_ready;
   logic [NCH*DW/8-1:0]   req_we;
   logic [NCH*AW-1:0]     req_addr;
   logic [NCH*DW-1:0]     req_wdata;
   logic [NCH-1:0]        resp_valid;
   logic [DW-1:0]         resp_rdata;
   logic                  mem_req;
   logic                  mem_addr_ok;
   logic [DW/8-1:0]       mem_we;
   logic [AW-1:0]         mem_addr;
   logic [DW-1:0]         mem_wdata;
   logic                  mem_data_ok;
   logic [DW-1:0]         mem_rdata;
   logic [$clog2(DEPTH):0] outstanding;
   logic                  err_orphan;

   int n_assert = 0;
   int n_fail   = 0;

   sram_req_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
      .clk         (clk),
      .resetn      (resetn),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_we      (req_we),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .resp_valid  (resp_valid),
      .resp_rdata  (resp_rdata),
      .mem_req     (mem_req),
      .mem_addr_ok (mem_addr_ok),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_data_ok (mem_data_ok),
      .mem_rdata   (mem_rdata),
      .outstanding (outstanding),
      .err_orphan  (err_orphan)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset with hostile inputs: all strobes must stay low
      resetn      = 1'b0;
      req_valid   = 2'b11;
      req_we      = '0;
      req_addr    = {32'h1C00_0000, 32'h1000_0000};
      req_wdata   = {32'hBBBB_0001, 32'hAAAA_0000};
      mem_addr_ok = 1'b1;
      mem_data_ok = 1'b1;
      mem_rdata   = 32'h0;
      #2;
      chk("rst_mem_req", mem_req, 0);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_resp_valid", resp_valid, 0);
      cyc();
      cyc();
      resetn      = 1'b1;
      req_valid   = '0;
      mem_addr_ok = 1'b0;
      mem_data_ok = 1'b0;
      #1;
      chk("rst_outstanding", outstanding, 0);
      chk("rst_orphan", err_orphan, 0);
      chk("rst_rr_ptr", dut.rr_ptr, 0);

      // Single read from channel 1
      req_valid   = 2'b10;
      mem_addr_ok = 1'b1;
      #1;
      chk("t1_ready_c0", req_ready, 2'b10);
      chk("t1_addr", mem_addr, 32'h1C00_0000);
      chk("t1_out_c0", outstanding, 0);
      cyc();
      req_valid   = '0;
      mem_addr_ok = 1'b0;
      #1;
      chk("t1_out_c1", outstanding, 1);
      chk("t1_resp_c1", resp_valid, 0);
      cyc();
      mem_data_ok = 1'b1;
      mem_rdata   = 32'hDEAD_BEEF;
      #1;
      chk("t1_resp_c2", resp_valid, 2'b10);
      chk("t1_rdata_c2", resp_rdata, 32'hDEAD_BEEF);
      chk("t1_out_c2", outstanding, 1);
      cyc();
      mem_data_ok = 1'b0;
      #1;
      chk("t1_out_c3", outstanding, 0);

      // Round-robin with both channels requesting; responses trail by one cycle
      for (int k = 0; k < 6; k++) begin
         req_valid   = 2'b11;
         mem_addr_ok = 1'b1;
         mem_data_ok = (k > 0);
         mem_rdata   = 32'hA000 + k;
         #1;
         chk("rr_grant", req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
         chk("rr_addr", mem_addr, (k % 2 == 0) ? 32'h1000_0000 : 32'h1C00_0000);
         chk("rr_out", outstanding, (k == 0) ? 0 : 1);
         if (k > 0) begin
            chk("rr_resp", resp_valid, (k % 2 == 1) ? 2'b01 : 2'b10);
            chk("rr_rdata", resp_rdata, 32'hA000 + k);
         end
         cyc();
      end
      req_valid   = '0;
      mem_addr_ok = 1'b0;
      mem_data_ok = 1'b1;
      #1;
      chk("rr_resp_last", resp_valid, 2'b10);
      cyc();
      mem_data_ok = 1'b0;
      #1;
      chk("rr_out_end", outstanding, 0);

      // Fill the ID FIFO, then check the stall and the no-bypass rule
      for (int k = 0; k < 4; k++) begin
         req_valid   = 2'b11;
         mem_addr_ok = 1'b1;
         #1;
         chk("full_grant", req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
         cyc();
      end
      #1;
      chk("full_out", outstanding, 4);
      chk("full_mem_req", mem_req, 0);
      chk("full_ready", req_ready, 0);
      cyc();
      mem_data_ok = 1'b1;
      #1;
      chk("full_pop_resp", resp_valid, 2'b01);
      chk("full_pop_mem_req", mem_req, 0);
      chk("full_pop_ready", req_ready, 0);
      cyc();
      mem_data_ok = 1'b0;
      #1;
      chk("full_after_out", outstanding, 3);
      chk("full_after_ready", req_ready, 2'b01);
      cyc();
      req_valid   = '0;
      mem_addr_ok = 1'b0;
      #1;
      chk("full_refill_out", outstanding, 4);
      for (int k = 0; k < 4; k++) begin
         mem_data_ok = 1'b1;
         #1;
         chk("full_drain_resp", resp_valid, (k % 2 == 0) ? 2'b10 : 2'b01);
         cyc();
      end
      mem_data_ok = 1'b0;
      #1;
      chk("full_drain_out", outstanding, 0);

      // Simultaneous push and pop with two outstanding
      req_valid   = 2'b10;
      mem_addr_ok = 1'b1;
      #1;
      chk("pp_grant_a", req_ready, 2'b10);
      cyc();
      req_valid = 2'b01;
      #1;
      chk("pp_grant_b", req_ready, 2'b01);
      cyc();
      req_valid = 2'b10;
      mem_data_ok = 1'b1;
      #1;
      chk("pp_out_before", outstanding, 2);
      chk("pp_grant_c", req_ready, 2'b10);
      chk("pp_resp_c", resp_valid, 2'b10);
      cyc();
      req_valid   = '0;
      mem_addr_ok = 1'b0;
      #1;
      chk("pp_out_after", outstanding, 2);
      chk("pp_resp_d", resp_valid, 2'b01);
      cyc();
      #1;
      chk("pp_resp_e", resp_valid, 2'b10);
      cyc();
      mem_data_ok = 1'b0;
      #1;
      chk("pp_out_end", outstanding, 0);

      // One channel-0 read to move the pointer to 1
      req_valid   = 2'b01;
      mem_addr_ok = 1'b1;
      cyc();
      req_valid   = '0;
      mem_addr_ok = 1'b0;
      mem_data_ok = 1'b1;
      cyc();
      mem_data_ok = 1'b0;

      // Backpressure on a channel-0 write
      req_valid = 2'b01;
      req_we    = {4'h0, 4'hF};
      req_addr  = {32'h1C00_0000, 32'h0000_0100};
      req_wdata = {32'hBBBB_0001, 32'h1234_5678};
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("bp_mem_req", mem_req, 1);
         chk("bp_ready", req_ready, 0);
         chk("bp_addr", mem_addr, 32'h0000_0100);
         chk("bp_wdata", mem_wdata, 32'h1234_5678);
         chk("bp_we", mem_we, 4'hF);
         chk("bp_rr_ptr", dut.rr_ptr, 1);
         cyc();
      end
      mem_addr_ok = 1'b1;
      #1;
      chk("bp_accept", req_ready, 2'b01);
      cyc();
      req_valid   = '0;
      req_we      = '0;
      mem_addr_ok = 1'b0;
      #1;
      chk("bp_out", outstanding, 1);
      mem_data_ok = 1'b1;
      #1;
      chk("bp_resp", resp_valid, 2'b01);
      cyc();
      mem_data_ok = 1'b0;

      // Orphan response on an empty FIFO
      mem_data_ok = 1'b1;
      #1;
      chk("orph_resp", resp_valid, 0);
      chk("orph_flag_pre", err_orphan, 0);
      cyc();
      mem_data_ok = 1'b0;
      #1;
      chk("orph_flag", err_orphan, 1);

      // Three outstanding, then reset mid-operation
      req_valid   = 2'b11;
      mem_addr_ok = 1'b1;
      cyc();
      cyc();
      req_valid = 2'b01;
      cyc();
      req_valid   = '0;
      mem_addr_ok = 1'b0;
      #1;
      chk("mid_out", outstanding, 3);
      chk("mid_rr_ptr", dut.rr_ptr, 1);
      chk("mid_orphan", err_orphan, 1);
      resetn = 1'b0;
      cyc();
      resetn = 1'b1;
      #1;
      chk("mid_rst_out", outstanding, 0);
      chk("mid_rst_orphan", err_orphan, 0);
      chk("mid_rst_rr_ptr", dut.rr_ptr, 0);
      mem_data_ok = 1'b1;
      #1;
      chk("post_rst_resp", resp_valid, 0);
      cyc();
      mem_data_ok = 1'b0;
      #1;
      chk("post_rst_orphan", err_orphan, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/sram_req_arbiter.md
# sram_req_arbiter

Parametrised N-channel arbiter that merges several SRAM-like request/response ports (e.g. the core's instruction and data ports) onto one shared memory port with pipelined, in-order responses. It grants requests round-robin, tracks up to DEPTH outstanding transactions in a channel-ID FIFO, and routes each returning response to the channel that issued it. It sits between the CPU pipeline stages and the single memory/bus bridge.

## Interface
- NCH, default 2: number of requesting channels (2..8).
- AW, default 32: address width.
- DW, default 32: data width; byte-enable width is DW/8.
- DEPTH, default 4: maximum outstanding transactions; power of two, 2..16.
- clk  in  1  clock; all logic rising-edge.
- resetn  in  1  reset, synchronous, active-low.
- req_valid  in  NCH  per-channel request valid.
- req_ready  out  NCH  per-channel grant; a request is accepted when req_valid[i] & req_ready[i].
- req_we  in  NCH*DW/8  per-channel byte write enables; all zero means read.
- req_addr  in  NCH*AW  per-channel address.
- req_wdata  in  NCH*DW  per-channel write data.
- resp_valid  out  NCH  one-hot response strobe, one cycle per transaction.
- resp_rdata  out  DW  response data, shared by all channels, valid with resp_valid.
- mem_req  out  1  memory request valid.
- mem_addr_ok  in  1  memory accepts the request this cycle.
- mem_we  out  DW/8  forwarded byte enables of the granted channel.
- mem_addr  out  AW  forwarded address.
- mem_wdata  out  DW  forwarded write data.
- mem_data_ok  in  1  memory returns one response (reads and writes both respond).
- mem_rdata  in  DW  response data.
- outstanding  out  $clog2(DEPTH)+1  number of issued, unanswered transactions.
- err_orphan  out  1  sticky: mem_data_ok seen while outstanding == 0.

## Operation
- Arbitration is combinational within the cycle: the candidate is the first channel with req_valid set, searching from rr_ptr upward and wrapping modulo NCH.
- mem_req = (any req_valid) & ~fifo_full; mem_we/addr/wdata are muxed from the candidate.
- req_ready[i] = (i == candidate) & mem_req & mem_addr_ok; at most one bit is set.
- On acceptance: push the candidate ID into the ID FIFO; set rr_ptr to candidate+1 (mod NCH). With no acceptance, rr_ptr holds.
- On mem_data_ok with the FIFO non-empty: pop the head ID; resp_valid[head] = 1 and resp_rdata = mem_rdata in the same cycle (combinational pass-through, no buffering).
- mem_data_ok with the FIFO empty: no resp_valid; err_orphan is set and held until reset.
- Push and pop in the same cycle: both take effect and outstanding is unchanged.
- A full FIFO blocks the grant even if a pop occurs in the same cycle (no bypass); the grant resumes the next cycle.
- Arithmetic: the FIFO pointers are $clog2(DEPTH)+1 bits and wrap naturally. Full means the pointers differ only in the MSB; empty means they are equal.

## Timing
- Reset values (resetn low at the clock edge): rr_ptr = 0, FIFO empty, outstanding = 0, err_orphan = 0. While resetn is low, mem_req = 0, req_ready = 0 and resp_valid = 0, regardless of inputs.
- Reset mid-operation discards all outstanding IDs. mem_data_ok arriving in the first cycle after reset counts as orphan.
- Request path latency is 0 cycles: request to mem_req is combinational. Response path latency is 0 cycles: mem_data_ok to resp_valid is combinational.
- A channel must hold req_valid and its payload stable until req_ready. The arbiter may move the grant to another channel only after an acceptance.
- Ordering: responses are strictly in issue order across all channels.
- Throughput: one acceptance and one response per cycle.

## Structure
- Shared package sram_arb_pkg holds:
  - the localparam helpers (ID width $clog2(NCH), count width);
  - the function for the rotating priority search (first-set-from-pointer).
- Sub-module id_fifo: parametrised synchronous FIFO (width = ID width, depth DEPTH) with push, pop, full, empty and count.
- The top level holds the arbiter, the muxes and the orphan flag.

## Test plan
- Single read: NCH=2; channel 1 reads 0x1C00_0000; memory gives addr_ok the same cycle and data_ok 2 cycles later with 0xDEAD_BEEF. Required: req_ready = 2'b10 in cycle 0; resp_valid = 2'b10 and resp_rdata = 0xDEAD_BEEF in cycle 2; outstanding goes 0 -> 1 -> 1 -> 0.
- Round-robin fairness: both channels hold req_valid for 6 cycles and addr_ok is always 1. Required: grant order 0,1,0,1,0,1; response IDs return in the same order.
- Full stall: DEPTH=4; 4 accepted reads, no data_ok. Required: outstanding = 4, mem_req = 0. When data_ok pulses, the response goes to the first issuer, and the next grant happens the cycle after, not the same cycle.
- Simultaneous push/pop: outstanding = 2; an acceptance and a data_ok in the same cycle. Required: outstanding stays 2, and the head ID is routed correctly.
- Backpressure: mem_addr_ok low for 3 cycles with channel 0 requesting. Required: mem_addr/mem_wdata stay stable, req_ready stays 0, rr_ptr is unchanged, and acceptance occurs on the first cycle addr_ok = 1.
- Orphan and reset: data_ok with an empty FIFO sets err_orphan = 1 with no resp_valid. Reset with 3 outstanding: next cycle outstanding = 0, err_orphan = 0, rr_ptr = 0.
